// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, IF/ID register, redirect/stall/trap handling
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h80000000,
    parameter logic [31:0] IRQ_VECTOR = 32'h80000004,
    parameter logic [31:0] EXC_VECTOR = 32'h80000008,
    parameter logic [31:0] NOP_INSTR  = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  id_jump,
    input  logic        id_branch,
    input  logic        id_branch_cond,
    input  logic [31:0] id_jump_target,
    input  logic [31:0] id_jr_target,
    input  logic        id_exception,
    input  logic        id_interrupt,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);
    logic [31:0] pc;
    logic        trap;
    logic        redirect;
    logic [31:0] redirectPc;

    assign imem_addr = pc;

    // Decode requests only count when decode holds a real instruction
    always_comb begin
        trap       = ifid_valid & (id_exception | id_interrupt);
        redirect   = ifid_valid & ((id_jump == 2'b01) | (id_jump == 2'b10) | (id_branch & id_branch_cond));
        redirectPc = (id_jump == 2'b10) ? id_jr_target : id_jump_target;
    end

    // PC and IF/ID update: reset > trap > stall > redirect > sequential fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            ifid_instr  <= NOP_INSTR;
            ifid_pc     <= '0;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else if (trap) begin
            pc         <= id_exception ? EXC_VECTOR : IRQ_VECTOR;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            if (redirect) begin
                pc         <= redirectPc;
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end else begin
                pc          <= pc + 32'd4;
                ifid_instr  <= imem_rdata;
                ifid_pc     <= pc;
                ifid_valid  <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage with a reference model checked every cycle
module tb_if_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  id_jump;
    logic        id_branch;
    logic        id_branch_cond;
    logic [31:0] id_jump_target;
    logic [31:0] id_jr_target;
    logic        id_exception;
    logic        id_interrupt;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    int compared = 0;
    int mismatched = 0;
    bit modelLive = 0;

    logic [31:0] mPc, mInstr, mIfPc, mCount;
    logic        mValid;

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .id_jump(id_jump),
        .id_branch(id_branch), .id_branch_cond(id_branch_cond),
        .id_jump_target(id_jump_target), .id_jr_target(id_jr_target),
        .id_exception(id_exception), .id_interrupt(id_interrupt),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: fixed word at the reset vector, address-derived words elsewhere
    function automatic logic [31:0] imemWord(input logic [31:0] a);
        return (a == 32'h80000000) ? 32'h20080001 : {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rdata = imemWord(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: where the fetch stream goes next, from the architectural rules
    always @(posedge clk) begin
        logic        live;
        logic        takeTrap;
        logic        jumps;
        logic [31:0] target;
        live     = mValid === 1'b1;
        takeTrap = live && (id_exception || id_interrupt);
        jumps    = live && (id_jump == 2'b01 || id_jump == 2'b10 || (id_branch && id_branch_cond));
        target   = (id_jump == 2'b10) ? id_jr_target : id_jump_target;
        if (reset) begin
            mPc = 32'h80000000; mInstr = 0; mIfPc = 0; mValid = 0; mCount = 0;
            modelLive = 1;
        end else if (takeTrap) begin
            mPc = id_exception ? 32'h80000008 : 32'h80000004; mInstr = 0; mValid = 0;
        end else if (stall) begin
        end else if (jumps) begin
            mPc = target; mInstr = 0; mValid = 0;
        end else begin
            mInstr = imemWord(mPc); mIfPc = mPc; mValid = 1; mCount = mCount + 1; mPc = mPc + 4;
        end
        #1;
        if (modelLive) begin
            chk("model.imem_addr", imem_addr, mPc);
            chk("model.ifid_instr", ifid_instr, mInstr);
            chk("model.ifid_pc", ifid_pc, mIfPc);
            chk("model.ifid_valid", {31'd0, ifid_valid}, {31'd0, mValid});
            chk("model.fetch_count", fetch_count, mCount);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect5(input string tag, input logic [31:0] a, input logic v,
                           input logic [31:0] ipc, input logic [31:0] cnt);
        chk({tag, ".addr"}, imem_addr, a);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
        chk({tag, ".ifid_pc"}, ifid_pc, ipc);
        chk({tag, ".count"}, fetch_count, cnt);
    endtask

    initial begin
        reset = 1; stall = 0; id_jump = 0; id_branch = 0; id_branch_cond = 0;
        id_jump_target = 0; id_jr_target = 0; id_exception = 0; id_interrupt = 0;
        repeat (3) cyc();
        expect5("reset", 32'h80000000, 0, 0, 0);
        chk("reset.instr", ifid_instr, 32'h0);
        // T1 first fetch
        reset = 0; cyc();
        expect5("t1", 32'h80000004, 1, 32'h80000000, 1);
        chk("t1.instr", ifid_instr, 32'h20080001);
        // T2 straight line then stall
        repeat (3) cyc();
        expect5("t2.run", 32'h80000010, 1, 32'h8000000C, 4);
        stall = 1; id_jump = 2'b01; id_jump_target = 32'h80000400;
        repeat (2) cyc();
        expect5("t2.stall", 32'h80000010, 1, 32'h8000000C, 4);
        chk("t2.stall.instr", ifid_instr, 32'h000CFFF3);
        stall = 0; id_jump = 0; cyc();
        expect5("t2.resume", 32'h80000014, 1, 32'h80000010, 5);
        // T3 jump
        id_jump = 2'b01; id_jump_target = 32'h80000040; cyc();
        expect5("t3.squash", 32'h80000040, 0, 32'h80000010, 5);
        chk("t3.instr", ifid_instr, 32'h0);
        id_jump = 0; cyc();
        expect5("t3.target", 32'h80000044, 1, 32'h80000040, 6);
        // T4 taken branch, bubble ignores branch, then not taken
        id_branch = 1; id_branch_cond = 1; id_jump_target = 32'h80000100; cyc();
        expect5("t4.taken", 32'h80000100, 0, 32'h80000040, 6);
        id_jump_target = 32'h80000200; cyc();
        expect5("t4.bubble", 32'h80000104, 1, 32'h80000100, 7);
        id_branch_cond = 0; cyc();
        expect5("t4.nottaken", 32'h80000108, 1, 32'h80000104, 8);
        id_branch = 0;
        // T5 jr held by stall
        id_jump = 2'b10; id_jr_target = 32'h00400010; stall = 1; cyc();
        expect5("t5.held", 32'h80000108, 1, 32'h80000104, 8);
        stall = 0; cyc();
        expect5("t5.jr", 32'h00400010, 0, 32'h80000104, 8);
        id_jump = 0; cyc();
        expect5("t5.user", 32'h00400014, 1, 32'h00400010, 9);
        // T6 exception beats interrupt and stall
        id_exception = 1; id_interrupt = 1; stall = 1; cyc();
        expect5("t6.exc", 32'h80000008, 0, 32'h00400010, 9);
        chk("t6.instr", ifid_instr, 32'h0);
        cyc();
        expect5("t6.bubble_stall", 32'h80000008, 0, 32'h00400010, 9);
        stall = 0; cyc();
        expect5("t6.bubble_run", 32'h8000000C, 1, 32'h80000008, 10);
        id_exception = 0; cyc();
        expect5("t6.irq", 32'h80000004, 0, 32'h80000008, 10);
        id_interrupt = 0; cyc();
        expect5("t6.after_irq", 32'h80000008, 1, 32'h80000004, 11);
        // Reset during a redirect
        id_jump = 2'b01; id_jump_target = 32'h80000300; reset = 1; cyc();
        expect5("t6.reset", 32'h80000000, 0, 0, 0);
        reset = 0; id_jump = 0; cyc();
        expect5("post_reset", 32'h80000004, 1, 32'h80000000, 1);
        // PC wrap and id_jump=11 treated as sequential
        id_jump = 2'b10; id_jr_target = 32'hFFFFFFFC; cyc();
        expect5("wrap.jr", 32'hFFFFFFFC, 0, 32'h80000000, 1);
        id_jump = 0; cyc();
        expect5("wrap.seq", 32'h00000000, 1, 32'hFFFFFFFC, 2);
        id_jump = 2'b11; id_jump_target = 32'h80000500; cyc();
        expect5("jump11", 32'h00000004, 1, 32'h00000000, 3);
        id_jump = 0;
        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
